// File: rtl/rggen_native_adapter_pkg.sv
// Shared types and constants for the native register-bus adapter.
package rggen_native_adapter_pkg;

  localparam int unsigned STATUS_WIDTH = 2;

  typedef logic [STATUS_WIDTH-1:0] status_t;

  localparam status_t STATUS_OKAY   = 2'b00;
  localparam status_t STATUS_EXOKAY = 2'b01;
  localparam status_t STATUS_SLVERR = 2'b10;
  localparam status_t STATUS_DECERR = 2'b11;

  typedef enum logic [1:0] {
    STATE_IDLE,
    STATE_BUSY,
    STATE_RESPONSE
  } state_e;

endpackage

// File: rtl/rggen_native_adapter_mux.sv
// Ready-masked OR reduction of per-slot status and read data.
module rggen_native_adapter_mux
  import rggen_native_adapter_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned REGISTERS = 1
)(
  input  logic [REGISTERS-1:0]              select,
  input  logic [STATUS_WIDTH*REGISTERS-1:0] reg_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0]    reg_read_data,
  output status_t                           status_c,
  output logic [BUS_WIDTH-1:0]              read_data_c
);

  always_comb begin
    status_c    = '0;
    read_data_c = '0;
    for (int unsigned i = 0; i < REGISTERS; i++) begin
      if (select[i]) begin
        status_c    = status_c | reg_status[STATUS_WIDTH*i+:STATUS_WIDTH];
        read_data_c = read_data_c | reg_read_data[BUS_WIDTH*i+:BUS_WIDTH];
      end
    end
  end

endmodule

// File: rtl/rggen_native_adapter.sv
// Host-to-register-slot adapter: decodes the block range, broadcasts the access
// to all slots and returns a single merged response.
module rggen_native_adapter
  import rggen_native_adapter_pkg::*;
#(
  parameter int unsigned            ADDRESS_WIDTH     = 8,
  parameter int unsigned            BUS_WIDTH         = 32,
  parameter int unsigned            REGISTERS         = 1,
  parameter bit [ADDRESS_WIDTH-1:0] BASE_ADDRESS      = '0,
  parameter int unsigned            BYTE_SIZE         = 256,
  parameter bit                     ERROR_STATUS      = 1'b0,
  parameter bit [BUS_WIDTH-1:0]     DEFAULT_READ_DATA = '0,
  parameter int unsigned            TIMEOUT           = 0
)(
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_req_valid,
  output logic                              o_req_ready,
  input  logic                              i_req_write,
  input  logic [ADDRESS_WIDTH-1:0]          i_req_address,
  input  logic [BUS_WIDTH-1:0]              i_req_write_data,
  input  logic [BUS_WIDTH/8-1:0]            i_req_strobe,
  output logic                              o_rsp_valid,
  input  logic                              i_rsp_ready,
  output logic [STATUS_WIDTH-1:0]           o_rsp_status,
  output logic [BUS_WIDTH-1:0]              o_rsp_read_data,
  output logic                              o_reg_valid,
  output logic                              o_reg_write,
  output logic [ADDRESS_WIDTH-1:0]          o_reg_address,
  output logic [BUS_WIDTH-1:0]              o_reg_write_data,
  output logic [BUS_WIDTH/8-1:0]            o_reg_strobe,
  input  logic [REGISTERS-1:0]              i_reg_active,
  input  logic [REGISTERS-1:0]              i_reg_ready,
  input  logic [STATUS_WIDTH*REGISTERS-1:0] i_reg_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0]    i_reg_read_data
);

  localparam int unsigned STRB_WIDTH    = BUS_WIDTH / 8;
  localparam int unsigned ALIGN_BITS    = $clog2(STRB_WIDTH);
  localparam int unsigned EXT_WIDTH     = ADDRESS_WIDTH + 1;
  localparam int unsigned COUNT_WIDTH   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TIMEOUT_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  localparam logic [ADDRESS_WIDTH-1:0] ADDRESS_MASK =
    ~(ADDRESS_WIDTH'((1 << ALIGN_BITS) - 1));
  localparam logic [EXT_WIDTH-1:0] RANGE_START = EXT_WIDTH'(BASE_ADDRESS);
  localparam logic [EXT_WIDTH-1:0] RANGE_LIMIT =
    EXT_WIDTH'(BASE_ADDRESS) + EXT_WIDTH'(BYTE_SIZE);
  localparam status_t UNMAPPED_STATUS = ERROR_STATUS ? STATUS_SLVERR : STATUS_OKAY;

  state_e                   state;
  logic                     write_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     write_data_q;
  logic [STRB_WIDTH-1:0]    strobe_q;
  status_t                  status_q;
  logic [BUS_WIDTH-1:0]     read_data_q;
  logic [COUNT_WIDTH-1:0]   count_q;

  logic [ADDRESS_WIDTH-1:0] aligned_address;
  logic [EXT_WIDTH-1:0]     ext_address;
  logic                     in_range;
  logic [REGISTERS-1:0]     ready_slots;
  logic                     timeout_hit;
  status_t                  merged_status;
  logic [BUS_WIDTH-1:0]     merged_read_data;

  // Range decode is done on the word-aligned address seen by the slots.
  assign aligned_address = i_req_address & ADDRESS_MASK;
  assign ext_address     = {1'b0, aligned_address};
  assign in_range        = (ext_address >= RANGE_START) && (ext_address < RANGE_LIMIT);
  assign ready_slots     = i_reg_active & i_reg_ready;
  assign timeout_hit     = (TIMEOUT != 0) && (count_q == COUNT_WIDTH'(TIMEOUT_LAST));

  rggen_native_adapter_mux #(
    .BUS_WIDTH (BUS_WIDTH),
    .REGISTERS (REGISTERS)
  ) u_mux (
    .select        (ready_slots),
    .reg_status    (i_reg_status),
    .reg_read_data (i_reg_read_data),
    .status_c      (merged_status),
    .read_data_c   (merged_read_data)
  );

  // Transaction FSM; every output field is a flop or a decode of the state flop.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= STATE_IDLE;
      write_q      <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      strobe_q     <= '0;
      status_q     <= '0;
      read_data_q  <= '0;
      count_q      <= '0;
    end else begin
      case (state)
        STATE_IDLE: begin
          if (i_req_valid) begin
            write_q      <= i_req_write;
            address_q    <= aligned_address;
            write_data_q <= i_req_write_data;
            strobe_q     <= i_req_write ? i_req_strobe : '1;
            count_q      <= '0;
            if (in_range) begin
              state <= STATE_BUSY;
            end else begin
              state       <= STATE_RESPONSE;
              status_q    <= STATUS_SLVERR;
              read_data_q <= DEFAULT_READ_DATA;
            end
          end
        end
        STATE_BUSY: begin
          if (ready_slots != '0) begin
            state       <= STATE_RESPONSE;
            status_q    <= merged_status;
            read_data_q <= write_q ? '0 : merged_read_data;
          end else if (i_reg_active == '0) begin
            state       <= STATE_RESPONSE;
            status_q    <= UNMAPPED_STATUS;
            read_data_q <= DEFAULT_READ_DATA;
          end else if (timeout_hit) begin
            state       <= STATE_RESPONSE;
            status_q    <= STATUS_SLVERR;
            read_data_q <= DEFAULT_READ_DATA;
          end else begin
            count_q <= count_q + COUNT_WIDTH'(1);
          end
        end
        STATE_RESPONSE: begin
          if (i_rsp_ready) begin
            state <= STATE_IDLE;
          end
        end
        default: state <= STATE_IDLE;
      endcase
    end
  end

  assign o_req_ready      = (state == STATE_IDLE);
  assign o_reg_valid      = (state == STATE_BUSY);
  assign o_rsp_valid      = (state == STATE_RESPONSE);
  assign o_reg_write      = write_q;
  assign o_reg_address    = address_q;
  assign o_reg_write_data = write_data_q;
  assign o_reg_strobe     = strobe_q;
  assign o_rsp_status     = status_q;
  assign o_rsp_read_data  = read_data_q;

endmodule

// File: doc/rggen_native_adapter.md
RGGEN_NATIVE_ADAPTER -- requirements
Module: rggen_native_adapter

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, meaning the byte-address width on both host and register sides.
REQ-002 SHALL have parameter BUS_WIDTH, default 32, meaning the data width; legal values are 8/16/32/64.
REQ-003 SHALL have parameter REGISTERS, default 1, meaning the number of downstream register slots.
REQ-004 SHALL have parameter BASE_ADDRESS, default '0, meaning the first byte address of the register block.
REQ-005 SHALL have parameter BYTE_SIZE, default 256, meaning the block span in bytes.
REQ-006 SHALL have parameter ERROR_STATUS, default 0, meaning unmapped in-range access returns SLVERR when 1 and OKAY when 0.
REQ-007 SHALL have parameter DEFAULT_READ_DATA, default '0, meaning the read data returned for unmapped or errored accesses.
REQ-008 SHALL have parameter TIMEOUT, default 0, meaning the watchdog limit in cycles; 0 disables the watchdog.
REQ-009 SHALL have port i_clk, input, 1, the single clock.
REQ-010 SHALL have port i_rst, input, 1, a synchronous active-high reset.
REQ-011 SHALL have host request ports i_req_valid (in, 1), o_req_ready (out, 1), i_req_write (in, 1), i_req_address (in, ADDRESS_WIDTH), i_req_write_data (in, BUS_WIDTH) and i_req_strobe (in, BUS_WIDTH/8).
REQ-012 SHALL have host response ports o_rsp_valid (out, 1), i_rsp_ready (in, 1), o_rsp_status (out, 2) and o_rsp_read_data (out, BUS_WIDTH).
REQ-013 SHALL have register broadcast outputs o_reg_valid (1), o_reg_write (1), o_reg_address (ADDRESS_WIDTH), o_reg_write_data (BUS_WIDTH) and o_reg_strobe (BUS_WIDTH/8).
REQ-014 SHALL have register return inputs i_reg_active (REGISTERS), i_reg_ready (REGISTERS), i_reg_status (2*REGISTERS) and i_reg_read_data (BUS_WIDTH*REGISTERS), each packed with slot 0 in the LSBs.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and RESPONSE.
REQ-016 SHALL drive o_req_ready=1 only in IDLE; a request is accepted when i_req_valid and o_req_ready are both 1.
REQ-017 SHALL, on acceptance, register write, address (low log2(BUS_WIDTH/8) bits forced to 0), write data and strobe; read accesses SHALL register strobe as all-ones.
REQ-018 SHALL move from IDLE to RESPONSE on acceptance of an address outside [BASE_ADDRESS, BASE_ADDRESS+BYTE_SIZE), with status SLVERR, read data DEFAULT_READ_DATA and o_reg_valid never asserted.
REQ-019 SHALL move from IDLE to BUSY on acceptance of an in-range address; o_reg_valid=1 for the whole of BUSY, with the registered fields held stable.
REQ-020 SHALL, in any BUSY cycle with i_reg_active all-zero, go to RESPONSE with status per ERROR_STATUS and read data DEFAULT_READ_DATA.
REQ-021 SHALL, in any BUSY cycle with at least one bit of (i_reg_active & i_reg_ready) set, go to RESPONSE.
REQ-022 SHALL, on that REQ-021 exit, capture as status the OR of i_reg_status and as read data the OR of i_reg_read_data, each taken over the ready slots only; writes SHALL return read data '0.
REQ-023 SHALL otherwise remain in BUSY.
REQ-024 SHALL, when TIMEOUT>0, count BUSY cycles and, on the cycle the count reaches TIMEOUT with no ready, go to RESPONSE with SLVERR and DEFAULT_READ_DATA; the counter SHALL clear on BUSY entry.
REQ-025 SHALL drive o_rsp_valid=1 throughout RESPONSE with status and read data held stable.
REQ-026 SHALL move from RESPONSE to IDLE when i_rsp_ready=1.
REQ-027 SHALL produce at least one cycle of IDLE between transactions; the minimum request-accept to response-valid latency SHALL be 2 cycles (1 for out-of-range).
REQ-028 SHALL encode status as OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.

Reset
REQ-029 SHALL, while i_rst=1 at a clock edge, enter IDLE and clear all captured fields, the counter and the response to 0; after reset o_req_ready=1, o_reg_valid=0 and o_rsp_valid=0.
REQ-030 SHALL, on reset in BUSY or RESPONSE, drop the transaction without producing a response.

Structure
REQ-031 SHALL place the state enum and the status constants in package rggen_native_adapter_pkg.
REQ-032 SHALL contain one sub-module, rggen_native_adapter_mux, implementing the ready-masked OR reduction of status and read data.

Verification
REQ-033 Bench: write 0x04, data 0xA5A5_0000, strobe 0xC; slot 1 active and ready after 3 cycles -> o_reg_valid held for exactly 3 cycles, response OKAY.
REQ-034 Bench: read 0x08; slot 2 ready on the first BUSY cycle with data 0x1234_5678 -> o_rsp_valid 2 cycles after accept, data 0x1234_5678.
REQ-035 Bench: read 0x0C, no slot active, ERROR_STATUS=1, DEFAULT_READ_DATA=0xDEAD_BEEF -> status SLVERR, data 0xDEAD_BEEF.
REQ-036 Bench: BASE_ADDRESS=0x40, BYTE_SIZE=0x20, access 0x10 -> no o_reg_valid, status SLVERR.
REQ-037 Bench: TIMEOUT=4, slot active but never ready -> SLVERR on the 4th BUSY cycle; hold i_rsp_ready=0 for 5 cycles -> response stays stable.
REQ-038 Bench: assert i_rst during BUSY -> next cycle IDLE, o_req_ready=1, no o_rsp_valid.
